cache_axi_bridge: RTL and testbench



---
 rtl/cache_axi_bridge.sv | 234 +++++++++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 628 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: turns the write-back cache's refill-read and victim-write
// requests into AXI master traffic. One read burst and one buffered write may
// be in flight at the same time; a read to the buffered line waits for its B.
module cache_axi_bridge #(
    parameter int ID_W  = 4,
    parameter int RD_ID = 0,
    parameter int WR_ID = 1
) (
    input  logic            clk,
    input  logic            reset,
    // cache read side
    input  logic            rd_req,
    input  logic [2:0]      rd_type,
    input  logic [31:0]     rd_addr,
    output logic            rd_rdy,
    output logic            ret_valid,
    output logic            ret_last,
    output logic [31:0]     ret_data,
    // cache write side
    input  logic            wr_req,
    input  logic [2:0]      wr_type,
    input  logic [31:0]     wr_addr,
    input  logic [3:0]      wr_wstrb,
    input  logic [127:0]    wr_data,
    output logic            wr_rdy,
    // AXI read address
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,
    // AXI read data
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    // AXI write address
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awvalid,
    input  logic            awready,
    // AXI write data
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    // AXI write response
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_e;

    r_state_e       r_state_q, r_state_d;
    logic [31:0]    ar_addr_q, ar_addr_d;
    logic [7:0]     ar_len_q, ar_len_d;
    logic [2:0]     ar_size_q, ar_size_d;

    w_state_e       w_state_q, w_state_d;
    logic [31:0]    wbuf_addr_q, wbuf_addr_d;
    logic [2:0]     wbuf_type_q, wbuf_type_d;
    logic [3:0]     wbuf_strb_q, wbuf_strb_d;
    logic [127:0]   wbuf_data_q, wbuf_data_d;
    logic [1:0]     beat_q, beat_d;
    logic           aw_done_q, aw_done_d;
    logic           w_done_q, w_done_d;

    logic           hazard;
    logic           rd_line;
    logic           wbuf_line;
    logic           beat_is_last;
    logic           aw_hs;
    logic           w_hs;
    logic           w_last_hs;

    // Response IDs and status codes carry nothing the cache needs.
    logic           unused_resp_fields;
    assign unused_resp_fields = ^{rid, rresp, bid, bresp};

    assign rd_line      = (rd_type == 3'b100);
    assign wbuf_line    = (wbuf_type_q == 3'b100);
    assign hazard       = (w_state_q != W_IDLE) && (rd_addr[31:4] == wbuf_addr_q[31:4]);
    assign rd_rdy       = (r_state_q == R_IDLE) && !hazard && !reset;

    assign arid         = ID_W'(RD_ID);
    assign araddr       = ar_addr_q;
    assign arlen        = ar_len_q;
    assign arsize       = ar_size_q;
    assign arburst      = 2'b01;
    assign ret_data     = rdata;

    assign awid         = ID_W'(WR_ID);
    assign awaddr       = wbuf_addr_q;
    assign awlen        = wbuf_line ? 8'd3 : 8'd0;
    assign awsize       = wbuf_line ? 3'd2 : {1'b0, wbuf_type_q[1:0]};
    assign awburst      = 2'b01;
    assign wdata        = wbuf_data_q[{beat_q, 5'b00000} +: 32];
    assign wstrb        = wbuf_line ? 4'hf : wbuf_strb_q;
    assign beat_is_last = ({6'b000000, beat_q} == awlen);
    assign wlast        = (w_state_q == W_SEND) && beat_is_last;

    // Read channel: accept a request, issue AR, forward R beats straight to the cache.
    always_comb begin
        r_state_d = r_state_q;
        ar_addr_d = ar_addr_q;
        ar_len_d  = ar_len_q;
        ar_size_d = ar_size_q;
        arvalid   = 1'b0;
        rready    = 1'b0;
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (rd_req && rd_rdy) begin
                    ar_addr_d = rd_addr;
                    ar_len_d  = rd_line ? 8'd3 : 8'd0;
                    ar_size_d = rd_line ? 3'd2 : {1'b0, rd_type[1:0]};
                    r_state_d = R_AR;
                end
            end
            R_AR: begin
                arvalid = 1'b1;
                if (arready) r_state_d = R_DATA;
            end
            R_DATA: begin
                rready    = 1'b1;
                ret_valid = rvalid;
                ret_last  = rvalid && rlast;
                if (rvalid && rlast) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read channel state and latched AR fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            ar_addr_q <= '0;
            ar_len_q  <= '0;
            ar_size_q <= '0;
        end else begin
            r_state_q <= r_state_d;
            ar_addr_q <= ar_addr_d;
            ar_len_q  <= ar_len_d;
            ar_size_q <= ar_size_d;
        end
    end

    // Write channel: buffer one victim, run AW and W independently, then wait for B.
    always_comb begin
        w_state_d   = w_state_q;
        wbuf_addr_d = wbuf_addr_q;
        wbuf_type_d = wbuf_type_q;
        wbuf_strb_d = wbuf_strb_q;
        wbuf_data_d = wbuf_data_q;
        beat_d      = beat_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        wr_rdy      = 1'b0;
        awvalid     = 1'b0;
        wvalid      = 1'b0;
        bready      = 1'b0;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        w_last_hs   = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                wr_rdy = !reset;
                if (wr_req) begin
                    wbuf_addr_d = wr_addr;
                    wbuf_type_d = wr_type;
                    wbuf_strb_d = wr_wstrb;
                    wbuf_data_d = wr_data;
                    beat_d      = 2'd0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    w_state_d   = W_SEND;
                end
            end
            W_SEND: begin
                awvalid   = !aw_done_q;
                wvalid    = !w_done_q;
                aw_hs     = awvalid && awready;
                w_hs      = wvalid && wready;
                w_last_hs = w_hs && beat_is_last;
                if (w_hs) beat_d = beat_q + 2'd1;
                if (aw_hs) aw_done_d = 1'b1;
                if (w_last_hs) w_done_d = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_last_hs)) w_state_d = W_RESP;
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write channel state, write buffer and per-channel progress flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q   <= W_IDLE;
            wbuf_addr_q <= '0;
            wbuf_type_q <= '0;
            wbuf_strb_q <= '0;
            wbuf_data_q <= '0;
            beat_q      <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            wbuf_addr_q <= wbuf_addr_d;
            wbuf_type_q <= wbuf_type_d;
            wbuf_strb_q <= wbuf_strb_d;
            wbuf_data_q <= wbuf_data_d;
            beat_q      <= beat_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
        end
    end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Testbench for cache_axi_bridge: directed scenarios plus randomized read and
// write transactions compared against a transaction-level reference model.
module tb_cache_axi_bridge;

    localparam int ID_W = 4;

    logic            clk;
    logic            reset;
    logic            rd_req;
    logic [2:0]      rd_type;
    logic [31:0]     rd_addr;
    logic            rd_rdy;
    logic            ret_valid;
    logic            ret_last;
    logic [31:0]     ret_data;
    logic            wr_req;
    logic [2:0]      wr_type;
    logic [31:0]     wr_addr;
    logic [3:0]      wr_wstrb;
    logic [127:0]    wr_data;
    logic            wr_rdy;
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    int checks;
    int errors;

    // Ready patterns for write transactions, indexed by cycle after the request.
    logic        wready_pat [40];
    logic        awready_pat[40];
    logic [31:0] beat_data  [4];
    logic [2:0]  type_choices[4];

    // Read capture
    int          cr_wait;
    logic        cr_timeout, cr_arvalid_t1, cr_ar_drop, cr_gap_valid, cr_rd_rdy_after;
    logic [48:0] cr_ar;
    logic        cr_rv[4];
    logic [31:0] cr_rd[4];
    logic        cr_rl[4];
    logic        cr_rr[4];

    // Write capture
    int          cw_n, caw_n, cw_last_cycle, caw_cycle, cresp_cycle;
    logic        cw_timeout, cwr_rdy_t1, cawvalid_t1, cwvalid_t1, cw_after;
    logic        cbready_drop, cwr_rdy_after;
    logic [48:0] caw;
    logic [31:0] cw_data[8];
    logic [3:0]  cw_strb[8];
    logic        cw_last[8];

    cache_axi_bridge #(.ID_W(ID_W), .RD_ID(0), .WR_ID(1)) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the bench can never hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: AXI length/size for a cache request type.
    function automatic logic [7:0] model_len(input logic [2:0] t);
        return (t == 3'b100) ? 8'd3 : 8'd0;
    endfunction

    function automatic logic [2:0] model_size(input logic [2:0] t);
        return (t == 3'b100) ? 3'd2 : {1'b0, t[1:0]};
    endfunction

    // Reference model: cycle (relative to request+1) at which B becomes ready,
    // given that AW and W are each offered every cycle until they complete.
    function automatic int model_resp_cycle(input int nbeats);
        int got = 0;
        int w_end = -1;
        int aw_end = -1;
        for (int c = 0; c < 40; c++) begin
            if (aw_end < 0 && awready_pat[c]) aw_end = c;
            if (w_end < 0 && wready_pat[c]) begin
                got++;
                if (got == nbeats) w_end = c;
            end
        end
        return ((aw_end > w_end) ? aw_end : w_end) + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rd_req = 0; rd_type = 0; rd_addr = 0;
        wr_req = 0; wr_type = 0; wr_addr = 0; wr_wstrb = 0; wr_data = '0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    endtask

    // Drive one read transaction and record what the DUT presented.
    task automatic run_read(input logic [31:0] addr, input logic [2:0] typ,
                            input int ar_delay, input int nbeats, input bit gaps);
        cr_wait = 0; cr_timeout = 0; cr_ar_drop = 0; cr_gap_valid = 0;
        rd_req = 1; rd_type = typ; rd_addr = addr;
        #1;
        while (!rd_rdy && cr_wait < 40) begin
            step(); #1; cr_wait++;
        end
        if (!rd_rdy) begin
            cr_timeout = 1; rd_req = 0;
            return;
        end
        step();
        rd_req = 0; rd_addr = ~addr; rd_type = 3'b111;
        #1;
        cr_arvalid_t1 = arvalid;
        for (int d = 0; d < ar_delay; d++) begin
            if (!arvalid) cr_ar_drop = 1;
            step(); #1;
        end
        arready = 1;
        #1;
        if (!arvalid) cr_ar_drop = 1;
        cr_ar = {araddr, arlen, arsize, arburst, arid};
        step();
        arready = 0;
        for (int i = 0; i < nbeats; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                rvalid = 0; #1;
                if (ret_valid) cr_gap_valid = 1;
                step();
            end
            rvalid = 1; rdata = beat_data[i]; rlast = (i == nbeats - 1);
            rid = 4'($urandom); rresp = 2'($urandom);
            #1;
            cr_rv[i] = ret_valid; cr_rd[i] = ret_data; cr_rl[i] = ret_last; cr_rr[i] = rready;
            step();
        end
        rvalid = 0; rlast = 0; rd_addr = addr;
        #1;
        cr_rd_rdy_after = rd_rdy;
    endtask

    // Drive one write transaction using the ready patterns and record what the DUT sent.
    task automatic run_write(input logic [31:0] addr, input logic [2:0] typ, input logic [3:0] strb,
                             input logic [127:0] data, input int b_delay);
        cw_n = 0; caw_n = 0; cw_last_cycle = -1; caw_cycle = -1; cresp_cycle = -1;
        cw_timeout = 0; cw_after = 0; cbready_drop = 0;
        wr_req = 1; wr_type = typ; wr_addr = addr; wr_wstrb = strb; wr_data = data;
        step();
        wr_req = 0; wr_addr = ~addr; wr_wstrb = ~strb; wr_data = ~data;
        for (int c = 0; c < 40; c++) begin
            wready = wready_pat[c]; awready = awready_pat[c];
            #1;
            if (c == 0) begin
                cwr_rdy_t1 = wr_rdy; cawvalid_t1 = awvalid; cwvalid_t1 = wvalid;
            end
            if (bready) begin
                cresp_cycle = c;
                break;
            end
            if (cw_last_cycle >= 0 && wvalid) cw_after = 1;
            if (wvalid && wready) begin
                if (cw_n < 8) begin
                    cw_data[cw_n] = wdata; cw_strb[cw_n] = wstrb; cw_last[cw_n] = wlast;
                end
                cw_n++;
                if (wlast) cw_last_cycle = c;
            end
            if (awvalid && awready) begin
                caw = {awaddr, awlen, awsize, awburst, awid};
                caw_n++;
                caw_cycle = c;
            end
            step();
        end
        wready = 0; awready = 0;
        if (cresp_cycle < 0) begin
            cw_timeout = 1;
            return;
        end
        for (int d = 0; d < b_delay; d++) begin
            if (!bready) cbready_drop = 1;
            step(); #1;
        end
        bvalid = 1; bid = 4'($urandom); bresp = 2'($urandom);
        #1;
        if (!bready) cbready_drop = 1;
        step();
        bvalid = 0;
        #1;
        cwr_rdy_after = wr_rdy;
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        set_idle();
        reset = 1;
        rd_req = 1; rvalid = 1; rlast = 1; bvalid = 1; arready = 1; awready = 1; wready = 1;
        step(); step(); #1;
        obs = {arvalid, awvalid, wvalid, rready, bready, ret_valid, ret_last, rd_rdy, wr_rdy};
        checks++;
        if (obs !== 9'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 9'b0);
        end
        set_idle();
        step();
        reset = 0;
        #1;
        obs = {arvalid, awvalid, wvalid, rready, bready, ret_valid, ret_last, rd_rdy, wr_rdy};
        checks++;
        if (obs !== 9'b000000011) begin
            errors++;
            $display("[TB] FAIL after_reset_idle: got %b expected %b", obs, 9'b000000011);
        end
        step();
    endtask

    task automatic test_line_read();
        for (int i = 0; i < 4; i++) beat_data[i] = 32'hA0 + i;
        run_read(32'h1C00_0040, 3'b100, 1, 4, 1'b0);
        checks++;
        if (cr_timeout || !cr_arvalid_t1 || cr_ar_drop) begin
            errors++;
            $display("[TB] FAIL line_read_ar: timeout=%0b arvalid_t1=%0b drop=%0b expected 0 1 0",
                     cr_timeout, cr_arvalid_t1, cr_ar_drop);
        end
        checks++;
        if (cr_ar !== {32'h1C00_0040, 8'd3, 3'd2, 2'b01, 4'd0}) begin
            errors++;
            $display("[TB] FAIL line_read_ar_fields: got %h expected %h", cr_ar,
                     {32'h1C00_0040, 8'd3, 3'd2, 2'b01, 4'd0});
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({cr_rr[i], cr_rv[i], cr_rd[i], cr_rl[i]} !== {1'b1, 1'b1, 32'hA0 + i, i == 3}) begin
                errors++;
                $display("[TB] FAIL line_read_beat%0d: got rr=%0b v=%0b d=%h l=%0b expected 1 1 %h %0b",
                         i, cr_rr[i], cr_rv[i], cr_rd[i], cr_rl[i], 32'hA0 + i, i == 3);
            end
        end
        checks++;
        if (cr_rd_rdy_after !== 1'b1) begin
            errors++;
            $display("[TB] FAIL line_read_rdy_after: got %b expected 1", cr_rd_rdy_after);
        end
        step();
    endtask

    task automatic test_line_write();
        logic [127:0] d;
        d = {32'h44, 32'h33, 32'h22, 32'h11};
        for (int c = 0; c < 40; c++) begin
            wready_pat[c] = (c == 1) ? 1'b0 : 1'b1;
            awready_pat[c] = 1'b1;
        end
        run_write(32'h0000_1230, 3'b100, 4'b0000, d, 2);
        checks++;
        if (cw_timeout || cwr_rdy_t1 !== 1'b0 || !cawvalid_t1 || !cwvalid_t1 || cw_n != 4 || caw_n != 1) begin
            errors++;
            $display("[TB] FAIL line_write_shape: timeout=%0b wr_rdy_t1=%0b awv=%0b wv=%0b beats=%0d aws=%0d expected 0 0 1 1 4 1",
                     cw_timeout, cwr_rdy_t1, cawvalid_t1, cwvalid_t1, cw_n, caw_n);
        end
        checks++;
        if (caw !== {32'h0000_1230, 8'd3, 3'd2, 2'b01, 4'd1}) begin
            errors++;
            $display("[TB] FAIL line_write_aw_fields: got %h expected %h", caw,
                     {32'h0000_1230, 8'd3, 3'd2, 2'b01, 4'd1});
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({cw_data[i], cw_strb[i], cw_last[i]} !== {32'h11 * (i + 1), 4'hf, i == 3}) begin
                errors++;
                $display("[TB] FAIL line_write_beat%0d: got d=%h s=%h l=%0b expected %h f %0b",
                         i, cw_data[i], cw_strb[i], cw_last[i], 32'h11 * (i + 1), i == 3);
            end
        end
        checks++;
        if (cresp_cycle != 5 || cbready_drop || cwr_rdy_after !== 1'b1) begin
            errors++;
            $display("[TB] FAIL line_write_resp: resp_cycle=%0d bready_drop=%0b wr_rdy_after=%0b expected 5 0 1",
                     cresp_cycle, cbready_drop, cwr_rdy_after);
        end
        step();
    endtask

    task automatic test_word_write();
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 40; c++) begin
            wready_pat[c] = 1'b1;
            awready_pat[c] = (c >= 6);
        end
        run_write(32'h0000_2344, 3'b010, 4'b0110, d, 0);
        checks++;
        if (cw_timeout || cw_n != 1 || caw_n != 1 || cw_after) begin
            errors++;
            $display("[TB] FAIL word_write_shape: timeout=%0b beats=%0d aws=%0d w_after=%0b expected 0 1 1 0",
                     cw_timeout, cw_n, caw_n, cw_after);
        end
        checks++;
        if ({cw_data[0], cw_strb[0], cw_last[0]} !== {d[31:0], 4'b0110, 1'b1}) begin
            errors++;
            $display("[TB] FAIL word_write_beat: got d=%h s=%b l=%0b expected %h 0110 1",
                     cw_data[0], cw_strb[0], cw_last[0], d[31:0]);
        end
        checks++;
        if (caw !== {32'h0000_2344, 8'd0, 3'd2, 2'b01, 4'd1} || caw_cycle != 6 || cresp_cycle != 7) begin
            errors++;
            $display("[TB] FAIL word_write_aw_wait: aw=%h aw_cycle=%0d resp=%0d expected %h 6 7",
                     caw, caw_cycle, cresp_cycle, {32'h0000_2344, 8'd0, 3'd2, 2'b01, 4'd1});
        end
        step();
    endtask

    task automatic test_min_write();
        for (int c = 0; c < 40; c++) begin
            wready_pat[c] = 1'b1;
            awready_pat[c] = 1'b1;
        end
        run_write(32'h0000_0100, 3'b001, 4'b0011, {4{$urandom}}, 0);
        checks++;
        if (cwr_rdy_t1 !== 1'b0 || cresp_cycle != 1 || cwr_rdy_after !== 1'b1) begin
            errors++;
            $display("[TB] FAIL min_write_timing: wr_rdy_t1=%0b resp_cycle=%0d wr_rdy_after=%0b expected 0 1 1",
                     cwr_rdy_t1, cresp_cycle, cwr_rdy_after);
        end
        step();
    endtask

    task automatic test_byte_read();
        beat_data[0] = 32'hDEAD_BE5A;
        run_read(32'h0000_0123, 3'b000, 0, 1, 1'b0);
        checks++;
        if (cr_timeout || cr_ar !== {32'h0000_0123, 8'd0, 3'd0, 2'b01, 4'd0}) begin
            errors++;
            $display("[TB] FAIL byte_read_ar: timeout=%0b got %h expected %h", cr_timeout, cr_ar,
                     {32'h0000_0123, 8'd0, 3'd0, 2'b01, 4'd0});
        end
        checks++;
        if ({cr_rv[0], cr_rd[0], cr_rl[0]} !== {1'b1, 32'hDEAD_BE5A, 1'b1}) begin
            errors++;
            $display("[TB] FAIL byte_read_beat: got v=%0b d=%h l=%0b expected 1 deadbe5a 1",
                     cr_rv[0], cr_rd[0], cr_rl[0]);
        end
        step();
    endtask

    task automatic test_hazard();
        set_idle();
        wr_req = 1; wr_type = 3'b010; wr_addr = 32'h0000_5670; wr_wstrb = 4'hf; wr_data = {4{32'h1234_5678}};
        step();
        wr_req = 0;
        rd_req = 1; rd_addr = 32'h0000_8000; rd_type = 3'b000;
        #1;
        checks++;
        if (rd_rdy !== 1'b1 || wr_rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hazard_other_line: rd_rdy=%b wr_rdy=%b expected 1 0", rd_rdy, wr_rdy);
        end
        step();
        rd_req = 0;
        #1;
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h0000_8000) begin
            errors++;
            $display("[TB] FAIL hazard_other_ar: arvalid=%b araddr=%h expected 1 00008000", arvalid, araddr);
        end
        arready = 1;
        step();
        arready = 0; rvalid = 1; rlast = 1; rdata = 32'h5A;
        #1;
        checks++;
        if ({ret_valid, ret_last, ret_data} !== {2'b11, 32'h5A}) begin
            errors++;
            $display("[TB] FAIL hazard_other_ret: got %b %b %h expected 1 1 0000005a", ret_valid, ret_last, ret_data);
        end
        step();
        rvalid = 0; rlast = 0;
        rd_req = 1; rd_addr = 32'h0000_5674; rd_type = 3'b010;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (rd_rdy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hazard_block_send%0d: rd_rdy=%b expected 0", k, rd_rdy);
            end
            step();
        end
        awready = 1; wready = 1;
        step();
        awready = 0; wready = 0;
        #1;
        checks++;
        if (bready !== 1'b1 || rd_rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hazard_block_resp: bready=%b rd_rdy=%b expected 1 0", bready, rd_rdy);
        end
        bvalid = 1;
        #1;
        checks++;
        if (rd_rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hazard_block_bvalid: rd_rdy=%b expected 0", rd_rdy);
        end
        step();
        bvalid = 0;
        #1;
        checks++;
        if (rd_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hazard_release: rd_rdy=%b expected 1", rd_rdy);
        end
        step();
        rd_req = 0;
        #1;
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h0000_5674) begin
            errors++;
            $display("[TB] FAIL hazard_read_ar: arvalid=%b araddr=%h expected 1 00005674", arvalid, araddr);
        end
        arready = 1;
        step();
        arready = 0; rvalid = 1; rlast = 1; rdata = 32'h77;
        step();
        set_idle();
        step();
    endtask

    task automatic test_reset_mid();
        logic [8:0] obs;
        set_idle();
        wr_req = 1; wr_type = 3'b100; wr_addr = 32'h4000_0000; wr_data = {4{$urandom}};
        step();
        wr_req = 0;
        rd_req = 1; rd_type = 3'b100; rd_addr = 32'h3000_0000;
        #1;
        checks++;
        if (rd_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid_accept: rd_rdy=%b expected 1", rd_rdy);
        end
        step();
        rd_req = 0; arready = 1;
        step();
        arready = 0; rvalid = 1; rdata = 32'hB0;
        step();
        rdata = 32'hB1;
        #1;
        reset = 1;
        #1;
        obs = {arvalid, awvalid, wvalid, rready, bready, ret_valid, ret_last, rd_rdy, wr_rdy};
        checks++;
        if (obs !== 9'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs: got %b expected %b", obs, 9'b0);
        end
        step();
        reset = 0;
        set_idle();
        #1;
        obs = {arvalid, awvalid, wvalid, rready, bready, ret_valid, ret_last, rd_rdy, wr_rdy};
        checks++;
        if (obs !== 9'b000000011) begin
            errors++;
            $display("[TB] FAIL reset_mid_idle: got %b expected %b", obs, 9'b000000011);
        end
        step();
        for (int i = 0; i < 4; i++) beat_data[i] = 32'hC0 + i;
        run_read(32'h2000_0080, 3'b100, 0, 4, 1'b0);
        checks++;
        if (cr_timeout || cr_ar !== {32'h2000_0080, 8'd3, 3'd2, 2'b01, 4'd0}) begin
            errors++;
            $display("[TB] FAIL reset_mid_reread_ar: timeout=%0b got %h", cr_timeout, cr_ar);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({cr_rv[i], cr_rd[i], cr_rl[i]} !== {1'b1, 32'hC0 + i, i == 3}) begin
                errors++;
                $display("[TB] FAIL reset_mid_reread_beat%0d: got v=%0b d=%h l=%0b expected 1 %h %0b",
                         i, cr_rv[i], cr_rd[i], cr_rl[i], 32'hC0 + i, i == 3);
            end
        end
        step();
    endtask

    task automatic test_random();
        logic [2:0]   t;
        logic [31:0]  a;
        logic [3:0]   s;
        logic [127:0] d;
        logic [31:0]  exp_word;
        int           n;
        int           exp_resp;
        for (int it = 0; it < 12; it++) begin
            t = type_choices[$urandom_range(0, 3)];
            a = $urandom;
            n = int'(model_len(t)) + 1;
            for (int i = 0; i < 4; i++) beat_data[i] = $urandom;
            run_read(a, t, $urandom_range(0, 3), n, 1'b1);
            checks++;
            if (cr_timeout || !cr_arvalid_t1 || cr_ar_drop || cr_gap_valid ||
                cr_ar !== {a, model_len(t), model_size(t), 2'b01, 4'd0}) begin
                errors++;
                $display("[TB] FAIL rand_read%0d_ar: flags=%0b%0b%0b%0b got %h expected %h", it,
                         cr_timeout, cr_arvalid_t1, cr_ar_drop, cr_gap_valid, cr_ar,
                         {a, model_len(t), model_size(t), 2'b01, 4'd0});
            end
            for (int i = 0; i < n; i++) begin
                checks++;
                if ({cr_rv[i], cr_rd[i], cr_rl[i]} !== {1'b1, beat_data[i], i == n - 1}) begin
                    errors++;
                    $display("[TB] FAIL rand_read%0d_beat%0d: got v=%0b d=%h l=%0b expected 1 %h %0b",
                             it, i, cr_rv[i], cr_rd[i], cr_rl[i], beat_data[i], i == n - 1);
                end
            end
            checks++;
            if (cr_rd_rdy_after !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rand_read%0d_rdy_after: got %b expected 1", it, cr_rd_rdy_after);
            end
            step();

            t = type_choices[$urandom_range(0, 3)];
            a = $urandom;
            s = 4'($urandom);
            d = {$urandom, $urandom, $urandom, $urandom};
            n = int'(model_len(t)) + 1;
            for (int c = 0; c < 40; c++) begin
                wready_pat[c]  = (c < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
                awready_pat[c] = (c < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            exp_resp = model_resp_cycle(n);
            run_write(a, t, s, d, $urandom_range(0, 3));
            checks++;
            if (cw_timeout || cw_n != n || caw_n != 1 || cw_after ||
                caw !== {a, model_len(t), model_size(t), 2'b01, 4'd1}) begin
                errors++;
                $display("[TB] FAIL rand_write%0d_aw: timeout=%0b beats=%0d/%0d aws=%0d after=%0b got %h expected %h",
                         it, cw_timeout, cw_n, n, caw_n, cw_after, caw,
                         {a, model_len(t), model_size(t), 2'b01, 4'd1});
            end
            for (int i = 0; i < n; i++) begin
                exp_word = (t == 3'b100) ? d[32*i +: 32] : d[31:0];
                checks++;
                if ({cw_data[i], cw_strb[i], cw_last[i]} !== {exp_word, (t == 3'b100) ? 4'hf : s, i == n - 1}) begin
                    errors++;
                    $display("[TB] FAIL rand_write%0d_beat%0d: got d=%h s=%h l=%0b expected %h %h %0b",
                             it, i, cw_data[i], cw_strb[i], cw_last[i], exp_word,
                             (t == 3'b100) ? 4'hf : s, i == n - 1);
                end
            end
            checks++;
            if (cresp_cycle != exp_resp || cbready_drop || cwr_rdy_after !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rand_write%0d_resp: resp_cycle=%0d bready_drop=%0b wr_rdy_after=%0b expected %0d 0 1",
                         it, cresp_cycle, cbready_drop, cwr_rdy_after, exp_resp);
            end
            step();
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        checks = 0;
        errors = 0;
        type_choices[0] = 3'b000;
        type_choices[1] = 3'b001;
        type_choices[2] = 3'b010;
        type_choices[3] = 3'b100;
        set_idle();
        reset = 1;
        test_reset();
        test_line_read();
        test_line_write();
        test_word_write();
        test_min_write();
        test_hazard();
        test_byte_read();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
